post_adder_preg: RTL and testbench

- Output end of the DSP48A1 datapath. It consumes the C operand after the C pipeline stage, the multiplier product, the D:A:B concatenation and the cascade input PCIN.
- X and Z operand multiplexers select the operands under OPMODE control. A 48-bit post-adder/subtractor combines them with a carry-in.
- The result is registered into the P register and the carry-out register, and drives P, PCOUT and CARRYOUT/CARRYOUTF toward the fabric and the next slice.

---
 rtl/post_adder_preg_if.sv | 28 ++
 rtl/post_adder_preg.sv | 95 +++++++++
 tb/tb_post_adder_preg.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/post_adder_preg_if.sv
// Operand and result bundle of the DSP48A1-style post-adder/P-register stage.
// The master side drives operands and receives results; the slave side is the datapath.
interface post_adder_preg_if;
  localparam int unsigned PW = 48;
  localparam int unsigned MW = 36;
  localparam int unsigned OW = 8;

  logic [OW-1:0] OPMODE;
  logic          CARRYIN;
  logic [PW-1:0] Cmux;
  logic [MW-1:0] M;
  logic [PW-1:0] DAB;
  logic [PW-1:0] PCIN;
  logic [PW-1:0] P;
  logic [PW-1:0] PCOUT;
  logic          CARRYOUT;
  logic          CARRYOUTF;

  modport master (
    output OPMODE, CARRYIN, Cmux, M, DAB, PCIN,
    input  P, PCOUT, CARRYOUT, CARRYOUTF
  );

  modport slave (
    input  OPMODE, CARRYIN, Cmux, M, DAB, PCIN,
    output P, PCOUT, CARRYOUT, CARRYOUTF
  );
endinterface

// File: rtl/post_adder_preg.sv
// X/Z operand muxes, 48-bit post-adder/subtractor with carry-in, and the
// optional OPMODE, carry-in and P/carry-out registers of a DSP48A1 slice.
module post_adder_preg #(
  parameter int unsigned PREG       = 1,
  parameter int unsigned OPMODEREG  = 1,
  parameter int unsigned CARRYINREG = 1,
  parameter string       CARRYINSEL = "OPMODE5"
) (
  input logic CLK,
  input logic RSTP,
  input logic CEP,
  input logic CEOPMODE,
  input logic CECARRYIN,
  post_adder_preg_if.slave bus
);
  localparam int unsigned PW = 48;
  localparam int unsigned MW = 36;
  localparam int unsigned OW = 8;
  localparam int unsigned RW = PW + 1;
  localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

  logic [OW-1:0] opmode_q, opmode_d;
  logic          cin_q, cin_d;
  logic [PW-1:0] p_q, p_d;
  logic          co_q, co_d;

  logic [OW-1:0] opm;
  logic          cin_sel;
  logic          cin;
  logic [PW-1:0] p_fb;
  logic [PW-1:0] x_op;
  logic [PW-1:0] z_op;
  logic [RW-1:0] r;

  // Effective control, operand selection and the 49-bit add/subtract.
  always_comb begin
    opm     = (OPMODEREG != 0) ? opmode_q : bus.OPMODE;
    cin_sel = CIN_FROM_PORT ? bus.CARRYIN : opm[5];
    cin     = (CARRYINREG != 0) ? cin_q : cin_sel;
    // Without a P register the feedback path reads 0 so no combinational loop forms.
    p_fb    = (PREG != 0) ? p_q : '0;

    x_op = '0;
    unique case (opm[1:0])
      2'd0: x_op = '0;
      2'd1: x_op = {{(PW-MW){1'b0}}, bus.M};
      2'd2: x_op = p_fb;
      2'd3: x_op = bus.DAB;
    endcase

    z_op = '0;
    unique case (opm[3:2])
      2'd0: z_op = '0;
      2'd1: z_op = bus.PCIN;
      2'd2: z_op = p_fb;
      2'd3: z_op = bus.Cmux;
    endcase

    if (opm[7]) r = {1'b0, z_op} - {1'b0, x_op} - RW'(cin);
    else        r = {1'b0, z_op} + {1'b0, x_op} + RW'(cin);
  end

  // Next-state for every register; reset has priority over the clock enables.
  always_comb begin
    opmode_d = opmode_q;
    cin_d    = cin_q;
    p_d      = p_q;
    co_d     = co_q;
    if (RSTP) begin
      opmode_d = '0;
      cin_d    = 1'b0;
      p_d      = '0;
      co_d     = 1'b0;
    end else begin
      if (CEOPMODE)  opmode_d = bus.OPMODE;
      if (CECARRYIN) cin_d    = cin_sel;
      if (CEP) begin
        p_d  = r[PW-1:0];
        co_d = r[PW];
      end
    end
  end

  always_ff @(posedge CLK) begin
    opmode_q <= opmode_d;
    cin_q    <= cin_d;
    p_q      <= p_d;
    co_q     <= co_d;
  end

  assign bus.P         = (PREG != 0) ? p_q  : r[PW-1:0];
  assign bus.CARRYOUT  = (PREG != 0) ? co_q : r[PW];
  assign bus.PCOUT     = bus.P;
  assign bus.CARRYOUTF = bus.CARRYOUT;
endmodule

// File: tb/tb_post_adder_preg.sv
// Directed bench for post_adder_preg: a fully registered instance and a
// fully combinational one, checked through an expected-result queue.
module tb_post_adder_preg;
  logic CLK = 1'b0;
  logic RSTP, CEP, CEOPMODE, CECARRYIN;

  always #5 CLK = ~CLK;

  post_adder_preg_if bus_r ();
  post_adder_preg_if bus_c ();

  post_adder_preg u_reg (
    .CLK(CLK), .RSTP(RSTP), .CEP(CEP), .CEOPMODE(CEOPMODE),
    .CECARRYIN(CECARRYIN), .bus(bus_r)
  );

  post_adder_preg #(.PREG(0), .OPMODEREG(0), .CARRYINREG(0)) u_comb (
    .CLK(CLK), .RSTP(RSTP), .CEP(CEP), .CEOPMODE(CEOPMODE),
    .CECARRYIN(CECARRYIN), .bus(bus_c)
  );

  typedef struct {
    string       tag;
    bit          comb;
    logic [47:0] p;
    logic        co;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input string tag, input bit comb, input logic [47:0] p, input logic co);
    exp_t e;
    e.tag = tag; e.comb = comb; e.p = p; e.co = co;
    exp_q.push_back(e);
  endtask

  // Pops the oldest expectation and compares all four outputs of the matching instance.
  task automatic check();
    exp_t        e;
    logic [97:0] obs, want;
    e = exp_q.pop_front();
    if (e.comb) obs = {bus_c.P, bus_c.PCOUT, bus_c.CARRYOUT, bus_c.CARRYOUTF};
    else        obs = {bus_r.P, bus_r.PCOUT, bus_r.CARRYOUT, bus_r.CARRYOUTF};
    want = {e.p, e.p, e.co, e.co};
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: P/PCOUT/CO/COF got %h %h %b %b expected %h %h %b %b", e.tag,
             obs[97:50], obs[49:2], obs[1], obs[0], want[97:50], want[49:2], want[1], want[0]);
    end
  endtask

  // Loads a new OPMODE with P frozen so control and carry-in registers settle.
  task automatic load_opmode(input logic [7:0] op);
    CEP = 1'b0;
    bus_r.OPMODE = op;
    tick();
    tick();
    CEP = 1'b1;
  endtask

  localparam logic [35:0] BIG_M = 36'h8_0000_0000;

  initial begin
    vectors = 0;
    miscompares = 0;
    RSTP = 1'b1; CEP = 1'b1; CEOPMODE = 1'b1; CECARRYIN = 1'b1;
    bus_r.OPMODE = 8'b0000_1100; bus_r.CARRYIN = 1'b0;
    bus_r.Cmux = 48'hFFFF; bus_r.M = '0; bus_r.DAB = '0; bus_r.PCIN = '0;
    bus_c.OPMODE = 8'b0000_0000; bus_c.CARRYIN = 1'b0;
    bus_c.Cmux = '0; bus_c.M = '0; bus_c.DAB = '0; bus_c.PCIN = '0;

    // Reset wins over CEP while Cmux is nonzero.
    push_exp("reset_edge1", 1'b0, 48'd0, 1'b0);
    tick(); check();
    push_exp("reset_held", 1'b0, 48'd0, 1'b0);
    tick(); check();

    // C + M: OPMODE needs two edges to reach P.
    RSTP = 1'b0;
    bus_r.OPMODE = 8'b0000_1101; bus_r.Cmux = 48'd100; bus_r.M = 36'd23;
    push_exp("add_latency1", 1'b0, 48'd0, 1'b0);
    tick(); check();
    push_exp("add_c_m", 1'b0, 48'd123, 1'b0);
    tick(); check();

    // Subtract with OPMODE carry: control, then carry-in register, then P.
    bus_r.OPMODE = 8'b1010_1101;
    push_exp("sub_cin", 1'b0, 48'd76, 1'b0);
    tick(); tick(); tick(); check();
    bus_r.Cmux = 48'd5; bus_r.M = 36'd10;
    push_exp("sub_borrow", 1'b0, 48'hFFFF_FFFF_FFFA, 1'b1);
    tick(); check();

    // Accumulate M onto P from zero.
    RSTP = 1'b1;
    tick();
    RSTP = 1'b0;
    bus_r.M = BIG_M;
    load_opmode(8'b0000_1001);
    push_exp("acc_1x", 1'b0, 48'h8_0000_0000, 1'b0);
    tick(); check();
    push_exp("acc_2x", 1'b0, 48'h10_0000_0000, 1'b0);
    tick(); check();
    push_exp("acc_3x", 1'b0, 48'h18_0000_0000, 1'b0);
    tick(); check();

    // CEP low holds P while inputs move.
    CEP = 1'b0;
    bus_r.M = 36'd5; bus_r.Cmux = 48'h1234_5678_9ABC;
    push_exp("ce_hold", 1'b0, 48'h18_0000_0000, 1'b0);
    tick(); tick(); check();

    // Reset mid-accumulation clears P and OPMODE; accumulation restarts from 0.
    CEP = 1'b1; RSTP = 1'b1;
    push_exp("rst_mid_acc", 1'b0, 48'd0, 1'b0);
    tick(); check();
    RSTP = 1'b0;
    push_exp("acc_restart0", 1'b0, 48'd0, 1'b0);
    tick(); check();
    push_exp("acc_restart1", 1'b0, 48'd5, 1'b0);
    tick(); check();
    push_exp("acc_restart2", 1'b0, 48'd10, 1'b0);
    tick(); check();

    // Wrap past 2^48-1 flags CARRYOUT for one cycle only.
    bus_r.Cmux = 48'hFFFF_FFFF_FFFF;
    load_opmode(8'b0000_1100);
    push_exp("preload_max", 1'b0, 48'hFFFF_FFFF_FFFF, 1'b0);
    tick(); check();
    bus_r.M = 36'd1;
    load_opmode(8'b0000_1001);
    push_exp("wrap_carry", 1'b0, 48'd0, 1'b1);
    tick(); check();
    push_exp("wrap_carry_clr", 1'b0, 48'd1, 1'b0);
    tick(); check();

    // Combinational instance: results appear in the same cycle.
    bus_c.OPMODE = 8'b0000_1111; bus_c.DAB = 48'd7; bus_c.Cmux = 48'd3;
    push_exp("comb_dab_c", 1'b1, 48'd10, 1'b0);
    #1; check();
    bus_c.OPMODE = 8'b0000_1011;
    push_exp("comb_z_fb_zero", 1'b1, 48'd7, 1'b0);
    #1; check();
    bus_c.OPMODE = 8'b0000_1110;
    push_exp("comb_x_fb_zero", 1'b1, 48'd3, 1'b0);
    #1; check();
    bus_c.OPMODE = 8'b1010_1101; bus_c.Cmux = 48'd5; bus_c.M = 36'd10;
    push_exp("comb_sub_borrow", 1'b1, 48'hFFFF_FFFF_FFFA, 1'b1);
    #1; check();
    RSTP = 1'b1;
    push_exp("comb_ignores_rst", 1'b1, 48'hFFFF_FFFF_FFFA, 1'b1);
    tick(); check();
    RSTP = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
